// File: rtl/round_key_sched.sv
// AES-128 round-key sequencer wrapped around a single-round key expansion
// block. Loads a cipher key on start, then emits round keys 0..NR over a
// valid/ready handshake, running expand_key once between emitted keys.

// expand_key: one step of the AES-128 key schedule. The substitution ROM is
// read synchronously, so y is valid one cycle after prevkey/round settle and
// only while they are held stable.
module expand_key (
    input  logic         clk,
    input  logic [127:0] prevkey,
    input  logic [3:0]   round,
    output logic [127:0] y
);
    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box entry: multiplicative inverse (x^254, which also maps 0 to 0)
    // followed by the AES affine transform.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant for rounds 1..10; other indices contribute nothing.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    logic [7:0]  sbox_rom [256];
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] temp_word;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;

    // Constant ROM contents, elaborated from the S-box definition.
    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
        assign sbox_rom[gi] = sbox_calc(8'(gi));
    end

    assign rot_word = {prevkey[23:0], prevkey[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
        logic [7:0] sub_reg;
        // Registered ROM read, one port per byte of RotWord(w3).
        always_ff @(posedge clk) begin
            sub_reg <= sbox_rom[rot_word[8*gi +: 8]];
        end
        assign sub_word[8*gi +: 8] = sub_reg;
    end

    assign temp_word = sub_word ^ {rcon(round), 24'h000000};
    assign w0 = prevkey[127:96] ^ temp_word;
    assign w1 = prevkey[95:64]  ^ w0;
    assign w2 = prevkey[63:32]  ^ w1;
    assign w3 = prevkey[31:0]   ^ w2;
    assign y  = {w0, w1, w2, w3};
endmodule

module round_key_sched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {IDLE, EMIT, EXP_WAIT, EXP_CAP} state_t;

    state_t       state_reg;
    state_t       state_next;
    logic [127:0] key_reg;
    logic [127:0] key_next;
    logic [3:0]   round_reg;
    logic [3:0]   round_next;
    logic         done_reg;
    logic         done_next;
    logic [3:0]   exp_round;
    logic [127:0] exp_y;

    // expand_key sees the held key register and the index of the key it is
    // producing; both stay constant through EXP_WAIT and EXP_CAP, which is
    // what the synchronous ROM inside needs. Round 0 never goes through it.
    assign exp_round = round_reg + 4'd1;

    expand_key u_expand_key (
        .clk     (clk),
        .prevkey (key_reg),
        .round   (exp_round),
        .y       (exp_y)
    );

    // State and schedule registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg <= IDLE;
            key_reg   <= '0;
            round_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            key_reg   <= key_next;
            round_reg <= round_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic: emit, wait for the ROM, capture the next round key.
    always_comb begin
        state_next = state_reg;
        key_next   = key_reg;
        round_next = round_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    key_next   = key_in;
                    round_next = 4'd0;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (round_reg == LAST_ROUND) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = EXP_WAIT;
                    end
                end
            end
            EXP_WAIT: begin
                state_next = EXP_CAP;
            end
            EXP_CAP: begin
                key_next   = exp_y;
                round_next = exp_round;
                state_next = EMIT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rk_valid = (state_reg == EMIT);
    assign rk_out   = key_reg;
    assign rk_round = round_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
endmodule

// File: tb/tb_round_key_sched.sv
// Testbench for round_key_sched: directed FIPS-197 scenarios plus randomized
// keys and back-pressure, checked against a word-level AES-128 key expansion.
module tb_round_key_sched;
    localparam int NR = 10;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_ready = 1'b0;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int checks = 0;
    int passes = 0;

    logic [127:0] model_keys [0:NR];

    logic [2047:0] sbox_bits = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    always #5 clk = ~clk;

    round_key_sched #(.NR(NR)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .start    (start),
        .key_in   (key_in),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = int'(b);
        return sbox_bits[2047 - 8*idx -: 8];
    endfunction

    // Reference key expansion in the word-by-word form w[i] = w[i-4] ^ temp.
    task automatic build_model(input logic [127:0] key);
        logic [31:0] w [0:4*(NR+1)-1];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after the start edge.
    task automatic do_start(input logic [127:0] key);
        start  = 1'b1;
        key_in = key;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        rk_ready = 1'b1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        nreset = 1'b0;
        start  = 1'b1;
        key_in = FIPS_KEY;
        repeat (3) @(negedge clk);
        start = 1'b0;
        checks++; if (rk_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rk_valid); else passes++;
        checks++; if (rk_out !== 128'h0) $display("FAIL reset_out: got %h want 0", rk_out); else passes++;
        checks++; if (rk_round !== 4'h0) $display("FAIL reset_round: got %0d want 0", rk_round); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
        nreset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy); else passes++;
        $display("reset: outputs idle after reset release");
    endtask

    task automatic test_fips_stream();
        bit exp_v;
        int r;
        build_model(FIPS_KEY);
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        for (int c = 1; c <= 3*NR+3; c++) begin
            exp_v = (c % 3 == 1) && (c <= 3*NR+1);
            checks++; if (rk_valid !== exp_v) $display("FAIL stream_valid cycle %0d: got %b want %b", c, rk_valid, exp_v); else passes++;
            if (exp_v) begin
                r = (c - 1) / 3;
                checks++; if (rk_round !== 4'(r)) $display("FAIL stream_round cycle %0d: got %0d want %0d", c, rk_round, r); else passes++;
                checks++; if (rk_out !== model_keys[r]) $display("FAIL stream_key round %0d: got %h want %h", r, rk_out, model_keys[r]); else passes++;
                $display("stream: round %0d key %h at cycle %0d", r, rk_out, c);
            end
            checks++; if (done !== (c == 3*NR+2)) $display("FAIL stream_done cycle %0d: got %b want %b", c, done, (c == 3*NR+2)); else passes++;
            checks++; if (busy !== (c <= 3*NR+1)) $display("FAIL stream_busy cycle %0d: got %b want %b", c, busy, (c <= 3*NR+1)); else passes++;
            if (c == 4) begin
                checks++; if (rk_out !== FIPS_R1) $display("FAIL fips_round1: got %h want %h", rk_out, FIPS_R1); else passes++;
            end
            if (c == 7) begin
                checks++; if (rk_out !== FIPS_R2) $display("FAIL fips_round2: got %h want %h", rk_out, FIPS_R2); else passes++;
            end
            if (c == 3*NR+1) begin
                checks++; if (rk_out !== FIPS_R10) $display("FAIL fips_round10: got %h want %h", rk_out, FIPS_R10); else passes++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        @(negedge clk);
        rk_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rk_valid) seen = 1'b1; else @(negedge clk);
        end
        checks++; if (!seen) $display("FAIL bp_round1_timeout: got no rk_valid want rk_valid"); else passes++;
        for (int k = 0; k < 5; k++) begin
            checks++; if (rk_valid !== 1'b1) $display("FAIL bp_hold_valid stall %0d: got %b want 1", k, rk_valid); else passes++;
            checks++; if (rk_round !== 4'd1) $display("FAIL bp_hold_round stall %0d: got %0d want 1", k, rk_round); else passes++;
            checks++; if (rk_out !== FIPS_R1) $display("FAIL bp_hold_key stall %0d: got %h want %h", k, rk_out, FIPS_R1); else passes++;
            @(negedge clk);
        end
        $display("backpressure: round 1 held %h for 5 cycles", rk_out);
        rk_ready = 1'b1;
        @(negedge clk);
        rk_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rk_valid) seen = 1'b1; else @(negedge clk);
        end
        checks++; if (!seen || rk_round !== 4'd2) $display("FAIL bp_round2_index: got %0d want 2", rk_round); else passes++;
        checks++; if (rk_out !== FIPS_R2) $display("FAIL bp_round2_key: got %h want %h", rk_out, FIPS_R2); else passes++;
        $display("backpressure: round 2 key %h after release", rk_out);
        wait_done(40, seen);
        checks++; if (!seen) $display("FAIL bp_done_timeout: got no done want done"); else passes++;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        bit injected;
        bit seen;
        build_model(FIPS_KEY);
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        injected = 1'b0;
        seen = 1'b0;
        for (int c = 1; c < 40 && !seen; c++) begin
            start = 1'b0;
            if (done) seen = 1'b1;
            if (rk_valid) begin
                if (rk_round > 4'(NR)) begin
                    checks++; $display("FAIL busy_round_range: got %0d want <= %0d", rk_round, NR);
                end else begin
                    checks++; if (rk_out !== model_keys[rk_round]) $display("FAIL busy_key round %0d: got %h want %h", rk_round, rk_out, model_keys[rk_round]); else passes++;
                end
                if (rk_round == 4'd3 && !injected) begin
                    start    = 1'b1;
                    key_in   = KEY2;
                    injected = 1'b1;
                    $display("start_while_busy: second start issued during round 3");
                end
                if (rk_round == 4'(NR)) begin
                    checks++; if (rk_out !== FIPS_R10) $display("FAIL busy_round10: got %h want %h", rk_out, FIPS_R10); else passes++;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (!seen) $display("FAIL busy_done_timeout: got no done want done"); else passes++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        rk_ready = 1'b1;
        do_start(FIPS_KEY);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (rk_valid && rk_round == 4'd5) seen = 1'b1; else @(negedge clk);
        end
        checks++; if (!seen) $display("FAIL mid_round5_timeout: got no round 5 want round 5"); else passes++;
        @(negedge clk);
        checks++; if (rk_valid !== 1'b0 || busy !== 1'b1) $display("FAIL mid_exp_wait: got valid %b busy %b want valid 0 busy 1", rk_valid, busy); else passes++;
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        checks++; if (rk_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", rk_valid); else passes++;
        checks++; if (rk_out !== 128'h0) $display("FAIL mid_out: got %h want 0", rk_out); else passes++;
        checks++; if (rk_round !== 4'h0) $display("FAIL mid_round: got %0d want 0", rk_round); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL mid_done: got %b want 0", done); else passes++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL mid_quiet cycle %0d: got done %b busy %b want 0 0", i, done, busy); else passes++;
        end
        $display("reset_mid: schedule abandoned, outputs cleared");
        build_model(KEY2);
        do_start(KEY2);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (rk_valid && rk_round == 4'(NR)) seen = 1'b1; else @(negedge clk);
        end
        checks++; if (!seen || rk_out !== KEY2_R10) $display("FAIL mid_key2_round10: got %h want %h", rk_out, KEY2_R10); else passes++;
        checks++; if (rk_out !== model_keys[NR]) $display("FAIL mid_key2_model: got %h want %h", rk_out, model_keys[NR]); else passes++;
        $display("reset_mid: new key round 10 = %h", rk_out);
        wait_done(10, seen);
        checks++; if (!seen) $display("FAIL mid_done_timeout: got no done want done"); else passes++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] key_a;
        logic [127:0] key_b;
        bit seen;
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        rk_ready = 1'b1;
        do_start(key_a);
        wait_done(40, seen);
        checks++; if (!seen) $display("FAIL b2b_done_timeout: got no done want done"); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_in_done: got %b want 0", busy); else passes++;
        do_start(key_b);
        checks++; if (rk_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", rk_valid); else passes++;
        checks++; if (rk_round !== 4'd0) $display("FAIL b2b_round: got %0d want 0", rk_round); else passes++;
        checks++; if (rk_out !== key_b) $display("FAIL b2b_key: got %h want %h", rk_out, key_b); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL b2b_done_width: got %b want 0", done); else passes++;
        $display("back_to_back: new schedule round 0 key %h", rk_out);
        wait_done(40, seen);
        checks++; if (!seen) $display("FAIL b2b_second_done_timeout: got no done want done"); else passes++;
        @(negedge clk);
    endtask

    task automatic test_random_backpressure();
        for (int k = 0; k < 6; k++) begin
            logic [127:0] key;
            logic [127:0] prev_out;
            logic [3:0]   prev_round;
            int exp_r;
            int cyc;
            bit have_prev;
            bit fin;
            key = {$urandom, $urandom, $urandom, $urandom};
            build_model(key);
            rk_ready = 1'b0;
            do_start(key);
            exp_r = 0;
            cyc = 0;
            have_prev = 1'b0;
            fin = 1'b0;
            prev_out = '0;
            prev_round = '0;
            while (!fin && cyc < 300) begin
                start = 1'b0;
                if (busy && $urandom_range(0, 7) == 0) begin
                    start  = 1'b1;
                    key_in = {$urandom, $urandom, $urandom, $urandom};
                end
                rk_ready = ($urandom_range(0, 9) < 6);
                if (have_prev) begin
                    checks++; if (rk_valid !== 1'b1 || rk_round !== prev_round || rk_out !== prev_out)
                        $display("FAIL rand_stall key %0d: got v%b r%0d %h want v1 r%0d %h", k, rk_valid, rk_round, rk_out, prev_round, prev_out);
                    else passes++;
                end
                have_prev = 1'b0;
                if (done) begin
                    checks++; if (exp_r != NR+1) $display("FAIL rand_done_early key %0d: got %0d keys want %0d", k, exp_r, NR+1); else passes++;
                    fin = 1'b1;
                end else if (rk_valid) begin
                    if (rk_ready) begin
                        if (exp_r > NR) begin
                            checks++; $display("FAIL rand_extra_key key %0d: got round %0d want none", k, rk_round);
                        end else begin
                            checks++; if (rk_round !== 4'(exp_r)) $display("FAIL rand_round key %0d: got %0d want %0d", k, rk_round, exp_r); else passes++;
                            checks++; if (rk_out !== model_keys[exp_r]) $display("FAIL rand_key key %0d round %0d: got %h want %h", k, exp_r, rk_out, model_keys[exp_r]); else passes++;
                        end
                        $display("random: key %0d round %0d accepted %h", k, rk_round, rk_out);
                        exp_r++;
                    end else begin
                        have_prev  = 1'b1;
                        prev_out   = rk_out;
                        prev_round = rk_round;
                    end
                end
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            checks++; if (!fin) $display("FAIL rand_timeout key %0d: got no done want done", k); else passes++;
            checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rand_after_done key %0d: got done %b busy %b want 0 0", k, done, busy); else passes++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fips_stream();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random_backpressure();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
